approx_adder_compare: RTL and testbench

// - Registered pair of 16-bit adders, exact and approximate, evaluated on the same operands.
// - Exact path: ripple-carry adder (CRA). Approximate path: FBA, an error-tolerant split

---
 rtl/approx_pkg.sv | 10 +
 rtl/fa_cell.sv | 17 +
 rtl/approx_adder_compare.sv | 133 +++++++++++++
 tb/tb_approx_adder_compare.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/approx_pkg.sv
// Shared constants and types for the exact/approximate adder comparison block.
package approx_pkg;

  localparam int WIDTH_DEF       = 16;
  localparam int APPROX_BITS_DEF = 8;

  typedef logic [WIDTH_DEF-1:0]        word_t;
  typedef logic signed [WIDTH_DEF+1:0] err_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder, the building block of both the exact ripple chain and
// the exact upper part of the approximate adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and majority carry.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
  end

endmodule

// File: rtl/approx_adder_compare.sv
// Registered exact ripple-carry adder alongside an FBA approximate adder on the
// same operands. Reports both sums and the signed error (approx - exact).
module approx_adder_compare
  import approx_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int APPROX_BITS = APPROX_BITS_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        a,
  input  logic [WIDTH-1:0]        b,
  input  logic                    cin,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        y_cra,
  output logic                    cout_cra,
  output logic [WIDTH-1:0]        y_fba,
  output logic                    cout_fba,
  output logic signed [WIDTH+1:0] err
);

  localparam int L = APPROX_BITS;

  // ---- stage p0: combinational exact and approximate sums ----

  logic [WIDTH:0]   cra_carry_p0;
  logic [WIDTH-1:0] y_cra_p0;
  logic             cout_cra_p0;

  assign cra_carry_p0[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cra
      fa_cell u_fa (
        .a  (a[gi]),
        .b  (b[gi]),
        .ci (cra_carry_p0[gi]),
        .s  (y_cra_p0[gi]),
        .co (cra_carry_p0[gi+1])
      );
    end
  endgenerate

  assign cout_cra_p0 = cra_carry_p0[WIDTH];

  // Lower part: once the scan from the top finds a bit where both operands are
  // 1, that bit and everything below it saturate to 1. sat_p0[i] is the OR of
  // the generate bits from L-1 down to i, so a set sat_p0 forces the bit high.
  logic [L-1:0] gen_p0;
  logic [L-1:0] sat_p0;
  logic [L-1:0] low_p0;

  assign gen_p0 = a[L-1:0] & b[L-1:0];
  assign sat_p0[L-1] = gen_p0[L-1];

  generate
    for (gi = L - 2; gi >= 0; gi--) begin : g_sat
      assign sat_p0[gi] = sat_p0[gi+1] | gen_p0[gi];
    end
    for (gi = 0; gi < L; gi++) begin : g_low
      assign low_p0[gi] = sat_p0[gi] | (a[gi] ^ b[gi]);
    end
  endgenerate

  // Upper part: exact add seeded with a carry speculated from the top
  // approximate bit only; cin is deliberately not used on this path.
  logic [WIDTH:L]   fba_carry_p0;
  logic [WIDTH-1:L] high_p0;
  logic [WIDTH-1:0] y_fba_p0;
  logic             cout_fba_p0;

  assign fba_carry_p0[L] = a[L-1] & b[L-1];

  generate
    for (gi = L; gi < WIDTH; gi++) begin : g_fba
      fa_cell u_fa (
        .a  (a[gi]),
        .b  (b[gi]),
        .ci (fba_carry_p0[gi]),
        .s  (high_p0[gi]),
        .co (fba_carry_p0[gi+1])
      );
    end
  endgenerate

  assign y_fba_p0    = {high_p0, low_p0};
  assign cout_fba_p0 = fba_carry_p0[WIDTH];

  // Both full sums are non-negative (WIDTH+1 bits), so zero-extend before subtracting.
  logic signed [WIDTH+1:0] err_p0;
  assign err_p0 = $signed({1'b0, cout_fba_p0, y_fba_p0})
                - $signed({1'b0, cout_cra_p0, y_cra_p0});

  // ---- stage p1: result registers ----

  logic                    vld_p1;
  logic [WIDTH-1:0]        y_cra_p1;
  logic                    cout_cra_p1;
  logic [WIDTH-1:0]        y_fba_p1;
  logic                    cout_fba_p1;
  logic signed [WIDTH+1:0] err_p1;

  // Load results on a valid sample, otherwise hold them; valid follows in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      y_cra_p1    <= '0;
      cout_cra_p1 <= 1'b0;
      y_fba_p1    <= '0;
      cout_fba_p1 <= 1'b0;
      err_p1      <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        y_cra_p1    <= y_cra_p0;
        cout_cra_p1 <= cout_cra_p0;
        y_fba_p1    <= y_fba_p0;
        cout_fba_p1 <= cout_fba_p0;
        err_p1      <= err_p0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign y_cra     = y_cra_p1;
  assign cout_cra  = cout_cra_p1;
  assign y_fba     = y_fba_p1;
  assign cout_fba  = cout_fba_p1;
  assign err       = err_p1;

endmodule

// File: tb/tb_approx_adder_compare.sv
// Directed-vector bench for approx_adder_compare with hand-computed results.
module tb_approx_adder_compare;
  import approx_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  in_valid;
  word_t a, b;
  logic  cin;
  logic  out_valid;
  word_t y_cra, y_fba;
  logic  cout_cra, cout_fba;
  err_t  err;

  int n_checks = 0;
  int n_pass   = 0;

  approx_adder_compare #(
    .WIDTH       (WIDTH_DEF),
    .APPROX_BITS (APPROX_BITS_DEF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .y_cra     (y_cra),
    .cout_cra  (cout_cra),
    .y_fba     (y_fba),
    .cout_fba  (cout_fba),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    word_t a;
    word_t b;
    logic  cin;
    word_t y_cra;
    logic  cout_cra;
    word_t y_fba;
    logic  cout_fba;
    err_t  err;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic vld, input word_t yc, input logic cc,
                         input word_t yf, input logic cf, input err_t e);
    chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, vld});
    chk({tag, ".y_cra"},     {16'b0, y_cra},     {16'b0, yc});
    chk({tag, ".cout_cra"},  {31'b0, cout_cra},  {31'b0, cc});
    chk({tag, ".y_fba"},     {16'b0, y_fba},     {16'b0, yf});
    chk({tag, ".cout_fba"},  {31'b0, cout_fba},  {31'b0, cf});
    chk({tag, ".err"},       {14'b0, err},       {14'b0, e});
  endtask

  // Drive one sample on the falling edge so it is stable at the next rising edge.
  task automatic drive(input logic v, input word_t ta, input word_t tb_, input logic tc);
    @(negedge clk);
    in_valid = v;
    a        = ta;
    b        = tb_;
    cin      = tc;
  endtask

  initial begin
    vecs[0] = '{16'h0000, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, err_t'(0)};
    vecs[1] = '{16'hAA55, 16'hFFFF, 1'b0, 16'hAA54, 1'b1, 16'hA9FF, 1'b1, err_t'(-85)};
    vecs[2] = '{16'hAA05, 16'hFF04, 1'b0, 16'hA909, 1'b1, 16'hA907, 1'b1, err_t'(-2)};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h0000, 1'b0, err_t'(-1)};
    vecs[4] = '{16'h0080, 16'h0080, 1'b0, 16'h0100, 1'b0, 16'h01FF, 1'b0, err_t'(255)};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, err_t'(0)};
    vecs[6] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 16'h553F, 1'b0, err_t'(-22)};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;

    // Reset state, with a valid input present that must be ignored.
    in_valid = 1'b1;
    a        = 16'h1234;
    b        = 16'h4321;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, err_t'(0));
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Table vectors, one per cycle.
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), 1'b1, vecs[i].y_cra, vecs[i].cout_cra,
              vecs[i].y_fba, vecs[i].cout_fba, vecs[i].err);
    end

    // Idle cycle: results hold the last vector, out_valid drops.
    drive(1'b0, 16'hAA55, 16'hFFFF, 1'b1);
    @(posedge clk);
    #1;
    chk_all("hold", 1'b0, 16'h5555, 1'b0, 16'h553F, 1'b0, err_t'(-22));

    // Mid-operation reset: valid sample, then reset asserted between edges.
    drive(1'b1, 16'hAA55, 16'hFFFF, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst.out_valid", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, err_t'(0));

    // Release with no valid input: outputs stay cleared.
    drive(1'b0, 16'h0080, 16'h0080, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_rst", 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, err_t'(0));

    // Next valid sample comes through normally.
    drive(1'b1, 16'h0080, 16'h0080, 1'b0);
    @(posedge clk);
    #1;
    chk_all("resume", 1'b1, 16'h0100, 1'b0, 16'h01FF, 1'b0, err_t'(255));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
